dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory.
- Requester D is the memory-access stage: lw/sw with byte-select. Requester F is instruction fetch, read-only.
- Grants one requester per transaction and drives the shared RAM port until the memory signals ready. Returns the read data and an ack to the granted requester, and raises a pipeline stall request while any access is outstanding.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants issued while F is waiting before F is forced to win.
- TIMEOUT, 255: BUSY cycles without ram_ready_i before the transaction is aborted with an error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- d_req_i  input  1  data-stage request; held until d_ack_o
- d_we_i  input  1  1 = write (sw), 0 = read (lw)
- d_addr_i  input  32  data address
- d_sel_i  input  4  byte lane select
- d_wdata_i  input  32  write data
- d_rdata_o  output  32  read data, valid while d_ack_o = 1, held afterwards
- d_ack_o  output  1  one-cycle completion pulse to D
- f_req_i  input  1  fetch request; held until f_ack_o
- f_addr_i  input  32  fetch address
- f_rdata_o  output  32  fetched word, valid while f_ack_o = 1, held afterwards
- f_ack_o  output  1  one-cycle completion pulse to F
- err_o  output  1  high together with ack when the transaction timed out
- stallreq_o  output  1  pipeline stall request
- ram_ce_o  output  1  RAM chip enable
- ram_we_o  output  1  RAM write enable
- ram_addr_o  output  32  RAM address
- ram_sel_o  output  4  RAM byte select
- ram_data_o  output  32  RAM write data
- ram_data_i  input  32  RAM read data
- ram_ready_i  input  1  RAM completion, sampled only in BUSY states

Behaviour:
- Reset (rst = 0, async):
  - state = IDLE; streak and timeout counters = 0.
  - All ram_* outputs, acks, err_o and both rdata outputs = 0.
  - Reset mid-transaction drops ram_ce_o immediately; no ack is issued.
- FSM states: IDLE, BUSY_D, BUSY_F, DONE.
- IDLE:
  - Only d_req_i = 1 → BUSY_D.
  - Only f_req_i = 1 → BUSY_F.
  - Both = 1 → BUSY_D, unless streak == STARVE_LIMIT, then BUSY_F.
  - Neither → stay in IDLE.
  - On the transition, the granted requester's addr/sel/wdata/we are latched into the registered ram_* outputs, and ram_ce_o = 1 from the next cycle.
- Fetch fields: ram_we_o = 0, ram_sel_o = 4'b1111, ram_data_o = 0.
- BUSY_x:
  - ram_* outputs are held stable.
  - ram_ready_i = 1 → DONE. ram_data_i is registered into x_rdata_o (for a D write, d_rdata_o is loaded with 0). Timeout counter cleared.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT: go to DONE with err flag set and x_rdata_o = 0.
- DONE (exactly one cycle):
  - x_ack_o = 1, and err_o = 1 if aborted.
  - ram_ce_o and ram_we_o = 0; other ram_* outputs = 0.
  - Both requests are ignored in this cycle, so the acked requester can drop req without being regranted.
  - Next state is IDLE.
- Minimum latency: req seen in IDLE at cycle 0 → ram_ce_o at cycle 1 → ready at cycle 1 → ack at cycle 2 → IDLE at cycle 3. Throughput is at most one access per 3 cycles.
- Streak counter (saturating at STARVE_LIMIT):
  - Incremented on each D grant made while f_req_i = 1.
  - Cleared on any F grant, or on a D grant with f_req_i = 0.
- stallreq_o is combinational: (d_req_i & ~d_ack_o) | (f_req_i & ~f_ack_o).
- Requests that drop before their ack are a protocol violation. A transaction already in BUSY still completes and its ack is still issued.
- d_ack_o and f_ack_o are never high in the same cycle.
- err_o is only ever high together with one ack.
- Addresses and data are passed unmodified. No alignment checking is done here.

Test Plan:
- Reset mid-BUSY_D:
  - Stimulus: rst low while ram_ce_o = 1.
  - Response: ram_ce_o = 0 in the same cycle (async); after release, state is IDLE, no ack, rdata = 0.
- Single read:
  - Stimulus: d_req_i = 1, d_we_i = 0, d_addr_i = 0x100; ram_ready_i = 1 one cycle after ram_ce_o, ram_data_i = 0xDEADBEEF.
  - Response: ram_addr_o = 0x100 and ram_ce_o = 1 at cycle 1; d_ack_o at cycle 2 with d_rdata_o = 0xDEADBEEF; stallreq_o high at cycles 0–1, low at cycle 2.
- Write:
  - Stimulus: sw to 0x20, sel = 4'b0011, wdata = 0x1234; ram_ready_i after 3 wait cycles.
  - Response: ram_we_o = 1 and ram_sel_o = 4'b0011 held for all 4 BUSY cycles; d_ack_o one cycle after ready.
- Contention/starvation (STARVE_LIMIT = 4):
  - Stimulus: d_req_i and f_req_i held continuously high, 1-cycle ready.
  - Response: grant order D, D, D, D, F, then D again; at most one ack per DONE cycle.
- Timeout (TIMEOUT = 255):
  - Stimulus: f_req_i = 1, ram_ready_i stuck at 0.
  - Response: f_ack_o = 1 with err_o = 1 and f_rdata_o = 0, exactly 255 BUSY cycles after ram_ce_o rose; next transaction completes with err_o = 0.
- Held request after ack:
  - Stimulus: D keeps d_req_i = 1 during its DONE cycle and then deasserts it.
  - Response: no second D grant; ram_ce_o stays 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the data-stage, fetch and RAM-side signals around the data-memory arbiter.
// The arbiter takes the slave modport; requesters and the RAM model take the master view.
interface dmem_arbiter_if;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        f_req_i;
    logic [31:0] f_addr_i;
    logic [31:0] f_rdata_o;
    logic        f_ack_o;
    logic        err_o;
    logic        stallreq_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;
    logic        ram_ready_i;

    modport slave (
        input  d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i,
        input  f_req_i, f_addr_i,
        input  ram_data_i, ram_ready_i,
        output d_rdata_o, d_ack_o, f_rdata_o, f_ack_o, err_o, stallreq_o,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o
    );

    modport master (
        output d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i,
        output f_req_i, f_addr_i,
        output ram_data_i, ram_ready_i,
        input  d_rdata_o, d_ack_o, f_rdata_o, f_ack_o, err_o, stallreq_o,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory: data stage (D) vs fetch (F),
// one transaction at a time, with fetch starvation guard and a ready timeout.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_F, DONE} state_t;

    state_t              state, state_nxt;
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
    logic                ram_ce_q, ram_ce_nxt;
    logic                ram_we_q, ram_we_nxt;
    logic [31:0]         ram_addr_q, ram_addr_nxt;
    logic [3:0]          ram_sel_q, ram_sel_nxt;
    logic [31:0]         ram_data_q, ram_data_nxt;
    logic                d_ack_q, d_ack_nxt;
    logic                f_ack_q, f_ack_nxt;
    logic                err_q, err_nxt;
    logic [31:0]         d_rdata_q, d_rdata_nxt;
    logic [31:0]         f_rdata_q, f_rdata_nxt;
    logic                grant_d;
    logic                timed_out;

    // D wins ties until the streak of D grants against a waiting F saturates
    assign grant_d   = bus.d_req_i && (!bus.f_req_i || (streak != STREAK_W'(STARVE_LIMIT)));
    assign timed_out = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            streak     <= '0;
            tmo_cnt    <= '0;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_sel_q  <= '0;
            ram_data_q <= '0;
            d_ack_q    <= 1'b0;
            f_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            d_rdata_q  <= '0;
            f_rdata_q  <= '0;
        end else begin
            state      <= state_nxt;
            streak     <= streak_nxt;
            tmo_cnt    <= tmo_nxt;
            ram_ce_q   <= ram_ce_nxt;
            ram_we_q   <= ram_we_nxt;
            ram_addr_q <= ram_addr_nxt;
            ram_sel_q  <= ram_sel_nxt;
            ram_data_q <= ram_data_nxt;
            d_ack_q    <= d_ack_nxt;
            f_ack_q    <= f_ack_nxt;
            err_q      <= err_nxt;
            d_rdata_q  <= d_rdata_nxt;
            f_rdata_q  <= f_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        streak_nxt   = streak;
        tmo_nxt      = tmo_cnt;
        ram_ce_nxt   = ram_ce_q;
        ram_we_nxt   = ram_we_q;
        ram_addr_nxt = ram_addr_q;
        ram_sel_nxt  = ram_sel_q;
        ram_data_nxt = ram_data_q;
        d_ack_nxt    = 1'b0;
        f_ack_nxt    = 1'b0;
        err_nxt      = 1'b0;
        d_rdata_nxt  = d_rdata_q;
        f_rdata_nxt  = f_rdata_q;

        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt    = BUSY_D;
                    tmo_nxt      = '0;
                    ram_ce_nxt   = 1'b1;
                    ram_we_nxt   = bus.d_we_i;
                    ram_addr_nxt = bus.d_addr_i;
                    ram_sel_nxt  = bus.d_sel_i;
                    ram_data_nxt = bus.d_wdata_i;
                    if (!bus.f_req_i) begin
                        streak_nxt = '0;
                    end else if (streak != STREAK_W'(STARVE_LIMIT)) begin
                        streak_nxt = streak + STREAK_W'(1);
                    end
                end else if (bus.f_req_i) begin
                    state_nxt    = BUSY_F;
                    tmo_nxt      = '0;
                    streak_nxt   = '0;
                    ram_ce_nxt   = 1'b1;
                    ram_we_nxt   = 1'b0;
                    ram_addr_nxt = bus.f_addr_i;
                    ram_sel_nxt  = 4'b1111;
                    ram_data_nxt = '0;
                end
            end
            BUSY_D, BUSY_F: begin
                if (bus.ram_ready_i || timed_out) begin
                    state_nxt    = DONE;
                    tmo_nxt      = '0;
                    err_nxt      = !bus.ram_ready_i;
                    ram_ce_nxt   = 1'b0;
                    ram_we_nxt   = 1'b0;
                    ram_addr_nxt = '0;
                    ram_sel_nxt  = '0;
                    ram_data_nxt = '0;
                    if (state == BUSY_D) begin
                        d_ack_nxt   = 1'b1;
                        // Writes and aborted accesses return zero data
                        d_rdata_nxt = (bus.ram_ready_i && !ram_we_q) ? bus.ram_data_i : 32'h0;
                    end else begin
                        f_ack_nxt   = 1'b1;
                        f_rdata_nxt = bus.ram_ready_i ? bus.ram_data_i : 32'h0;
                    end
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ram_ce_o   = ram_ce_q;
    assign bus.ram_we_o   = ram_we_q;
    assign bus.ram_addr_o = ram_addr_q;
    assign bus.ram_sel_o  = ram_sel_q;
    assign bus.ram_data_o = ram_data_q;
    assign bus.d_ack_o    = d_ack_q;
    assign bus.f_ack_o    = f_ack_q;
    assign bus.err_o      = err_q;
    assign bus.d_rdata_o  = d_rdata_q;
    assign bus.f_rdata_o  = f_rdata_q;

    // Stall from request until its ack cycle, combinationally
    assign bus.stallreq_o = (bus.d_req_i & ~d_ack_q) | (bus.f_req_i & ~f_ack_q);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: reset, read, write, contention,
// timeout and held-request cases with hand-computed expectations.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Land 2 time units after a rising edge: registered outputs settled, safe to drive
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic        exp_d;
        logic [31:0] exp_addr;
        int          ce_cycles;
        n_checks        = 0;
        n_pass          = 0;
        rst             = 1'b0;
        bus.d_req_i     = 1'b0;
        bus.d_we_i      = 1'b0;
        bus.d_addr_i    = '0;
        bus.d_sel_i     = '0;
        bus.d_wdata_i   = '0;
        bus.f_req_i     = 1'b0;
        bus.f_addr_i    = '0;
        bus.ram_data_i  = '0;
        bus.ram_ready_i = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ce", 32'(bus.ram_ce_o), 32'h0);
        check("rst_we", 32'(bus.ram_we_o), 32'h0);
        check("rst_addr", bus.ram_addr_o, 32'h0);
        check("rst_dack", 32'(bus.d_ack_o), 32'h0);
        check("rst_fack", 32'(bus.f_ack_o), 32'h0);
        check("rst_err", 32'(bus.err_o), 32'h0);
        check("rst_drdata", bus.d_rdata_o, 32'h0);
        rst = 1'b1;
        tick();

        // Single read: cycle 0 request
        bus.d_req_i  = 1'b1;
        bus.d_we_i   = 1'b0;
        bus.d_addr_i = 32'h100;
        bus.d_sel_i  = 4'hF;
        #1 check("rd_stall_c0", 32'(bus.stallreq_o), 32'h1);
        tick();
        check("rd_ce_c1", 32'(bus.ram_ce_o), 32'h1);
        check("rd_addr_c1", bus.ram_addr_o, 32'h100);
        check("rd_we_c1", 32'(bus.ram_we_o), 32'h0);
        bus.ram_ready_i = 1'b1;
        bus.ram_data_i  = 32'hDEADBEEF;
        #1 check("rd_stall_c1", 32'(bus.stallreq_o), 32'h1);
        tick();
        check("rd_ack_c2", 32'(bus.d_ack_o), 32'h1);
        check("rd_data_c2", bus.d_rdata_o, 32'hDEADBEEF);
        check("rd_err_c2", 32'(bus.err_o), 32'h0);
        check("rd_ce_c2", 32'(bus.ram_ce_o), 32'h0);
        check("rd_stall_c2", 32'(bus.stallreq_o), 32'h0);
        bus.ram_ready_i = 1'b0;
        bus.d_req_i     = 1'b0;
        tick();
        check("rd_ack_c3", 32'(bus.d_ack_o), 32'h0);
        check("rd_data_held", bus.d_rdata_o, 32'hDEADBEEF);

        // Reset in the middle of a D transaction
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h200;
        tick();
        check("mrst_ce_busy", 32'(bus.ram_ce_o), 32'h1);
        rst         = 1'b0;
        bus.d_req_i = 1'b0;
        #1 check("mrst_ce_async", 32'(bus.ram_ce_o), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("mrst_dack", 32'(bus.d_ack_o), 32'h0);
        check("mrst_drdata", bus.d_rdata_o, 32'h0);
        tick();
        check("mrst_ce_idle", 32'(bus.ram_ce_o), 32'h0);
        check("mrst_dack2", 32'(bus.d_ack_o), 32'h0);

        // Write with three wait cycles
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b1;
        bus.d_addr_i  = 32'h20;
        bus.d_sel_i   = 4'b0011;
        bus.d_wdata_i = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("wr_ce_%0d", i), 32'(bus.ram_ce_o), 32'h1);
            check($sformatf("wr_we_%0d", i), 32'(bus.ram_we_o), 32'h1);
            check($sformatf("wr_sel_%0d", i), 32'(bus.ram_sel_o), 32'h3);
            check($sformatf("wr_addr_%0d", i), bus.ram_addr_o, 32'h20);
            check($sformatf("wr_wdata_%0d", i), bus.ram_data_o, 32'h1234);
            check($sformatf("wr_ack_%0d", i), 32'(bus.d_ack_o), 32'h0);
            if (i == 3) begin
                bus.ram_ready_i = 1'b1;
                bus.ram_data_i  = 32'hFFFFFFFF;
            end
        end
        tick();
        check("wr_ack", 32'(bus.d_ack_o), 32'h1);
        check("wr_rdata_zero", bus.d_rdata_o, 32'h0);
        check("wr_we_done", 32'(bus.ram_we_o), 32'h0);
        bus.ram_ready_i = 1'b0;
        bus.d_req_i     = 1'b0;
        bus.d_we_i      = 1'b0;
        tick();

        // Contention: expected grant order D, D, D, D, F, D
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'hD00;
        bus.d_sel_i  = 4'hF;
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 32'hF00;
        for (int g = 0; g < 6; g++) begin
            exp_d    = (g != 4);
            exp_addr = exp_d ? 32'hD00 : 32'hF00;
            tick();
            check($sformatf("ct_ce_%0d", g), 32'(bus.ram_ce_o), 32'h1);
            check($sformatf("ct_addr_%0d", g), bus.ram_addr_o, exp_addr);
            check($sformatf("ct_sel_%0d", g), 32'(bus.ram_sel_o), 32'hF);
            bus.ram_ready_i = 1'b1;
            bus.ram_data_i  = 32'h1000 + 32'(g);
            tick();
            check($sformatf("ct_dack_%0d", g), 32'(bus.d_ack_o), 32'(exp_d));
            check($sformatf("ct_fack_%0d", g), 32'(bus.f_ack_o), 32'(!exp_d));
            if (exp_d) check($sformatf("ct_drd_%0d", g), bus.d_rdata_o, 32'h1000 + 32'(g));
            else       check($sformatf("ct_frd_%0d", g), bus.f_rdata_o, 32'h1000 + 32'(g));
            bus.ram_ready_i = 1'b0;
            if (g == 5) begin
                bus.d_req_i = 1'b0;
                bus.f_req_i = 1'b0;
            end
            tick();
            check($sformatf("ct_ce_idle_%0d", g), 32'(bus.ram_ce_o), 32'h0);
        end
        tick();
        check("ct_no_regrant", 32'(bus.ram_ce_o), 32'h0);

        // Timeout on a fetch: RAM never signals ready
        bus.f_req_i    = 1'b1;
        bus.f_addr_i   = 32'h40;
        bus.ram_data_i = 32'h5A5A5A5A;
        ce_cycles      = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (bus.f_ack_o) break;
            if (bus.ram_ce_o) ce_cycles++;
        end
        check("to_busy_cycles", 32'(ce_cycles), 32'd255);
        check("to_fack", 32'(bus.f_ack_o), 32'h1);
        check("to_err", 32'(bus.err_o), 32'h1);
        check("to_frdata", bus.f_rdata_o, 32'h0);
        bus.f_req_i = 1'b0;
        tick();
        check("to_err_clear", 32'(bus.err_o), 32'h0);

        // Follow-up fetch completes normally
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 32'h44;
        tick();
        check("fu_addr", bus.ram_addr_o, 32'h44);
        check("fu_we", 32'(bus.ram_we_o), 32'h0);
        bus.ram_ready_i = 1'b1;
        bus.ram_data_i  = 32'hCAFEF00D;
        tick();
        check("fu_fack", 32'(bus.f_ack_o), 32'h1);
        check("fu_err", 32'(bus.err_o), 32'h0);
        check("fu_frdata", bus.f_rdata_o, 32'hCAFEF00D);
        bus.ram_ready_i = 1'b0;
        bus.f_req_i     = 1'b0;
        tick();

        // D holds its request through DONE, then drops it in IDLE
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h80;
        tick();
        bus.ram_ready_i = 1'b1;
        bus.ram_data_i  = 32'h00C0FFEE;
        tick();
        check("hd_ack", 32'(bus.d_ack_o), 32'h1);
        check("hd_ce_done", 32'(bus.ram_ce_o), 32'h0);
        bus.ram_ready_i = 1'b0;
        tick();
        bus.d_req_i = 1'b0;
        check("hd_ce_idle", 32'(bus.ram_ce_o), 32'h0);
        tick();
        check("hd_no_regrant", 32'(bus.ram_ce_o), 32'h0);
        check("hd_no_ack", 32'(bus.d_ack_o), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
